// File: rtl/output_collector_pkg.sv
// rtl/output_collector_pkg.sv - shared FSM state, quantizer and accumulator sizing for output_collector
package output_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int SHIFT_W = 5;

    // Guard bits so that MAX_nPASS worst-case partial sums never wrap.
    function automatic int acc_width(input int o_width, input int max_npass);
        return o_width + $clog2(max_npass);
    endfunction

endpackage

// File: rtl/collector_fifo.sv
// rtl/collector_fifo.sv - synchronous first-word-fall-through FIFO for one output column
module collector_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_data = mem_q[rptr_q[AW-1:0]];

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        dropped = push & full & ~do_pop;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/output_collector.sv
// rtl/output_collector.sv - per-column multi-pass accumulation, quantization and round-robin output
module output_collector
    import output_collector_pkg::*;
#(
    parameter int nBanks     = 2,
    parameter int nCols      = 4,
    parameter int oWidth     = 33,
    parameter int qWidth     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_nPASS  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_load,
    input  logic [$clog2(MAX_nPASS):0]    cfg_npass,
    input  logic [4:0]                    cfg_shift,
    input  logic                          cfg_relu,
    input  logic [nBanks*nCols*oWidth-1:0] din,
    input  logic [nCols-1:0]              din_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [nBanks*qWidth-1:0]      out_data,
    output logic [$clog2(nCols)-1:0]      out_col,
    output logic                          busy,
    output logic [nCols-1:0]              ovf
);

    localparam int ACC_W  = acc_width(oWidth, MAX_nPASS);
    localparam int CW     = $clog2(MAX_nPASS) + 1;
    localparam int CIDX_W = $clog2(nCols);
    localparam int QD_W   = nBanks * qWidth;
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((64'sd1 <<< (qWidth - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] Q_MIN = -Q_MAX - 1;

    state_t                    state_q, state_d;
    logic [CW-1:0]             npass_q, npass_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic                      relu_q, relu_d;
    logic [CW-1:0]             cnt_q [nCols];
    logic [CW-1:0]             cnt_d [nCols];
    logic signed [ACC_W-1:0]   acc_q [nCols][nBanks];
    logic signed [ACC_W-1:0]   acc_d [nCols][nBanks];
    logic signed [ACC_W-1:0]   sum_w [nCols][nBanks];
    logic signed [ACC_W-1:0]   stage_q [nCols][nBanks];
    logic signed [ACC_W-1:0]   stage_d [nCols][nBanks];
    logic [nCols-1:0]          stage_valid_q, stage_valid_d;
    logic [nCols-1:0]          ovf_q, ovf_d;
    logic [CIDX_W-1:0]         ptr_q, ptr_d;
    logic                      lock_q, lock_d;
    logic [CIDX_W-1:0]         lock_col_q, lock_col_d;

    logic [QD_W-1:0]           q_data [nCols];
    logic [QD_W-1:0]           fifo_head [nCols];
    logic [nCols-1:0]          fifo_empty, fifo_full, fifo_drop, fifo_pop;
    logic                      found;
    logic [CIDX_W-1:0]         pick_col, cand, cur_col;
    logic                      handshake;
    logic                      acc_active;

    // Round to nearest, shift, optional ReLU, then saturate into qWidth.
    function automatic logic [qWidth-1:0] quantize(input logic signed [ACC_W-1:0] x,
                                                   input logic [SHIFT_W-1:0] sh,
                                                   input logic relu);
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] r;
        rnd = '0;
        if (sh != '0) begin
            rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1);
        end
        r = $signed({x[ACC_W-1], x}) + rnd;
        r = r >>> sh;
        if (relu && r[ACC_W]) begin
            r = '0;
        end
        if (r > Q_MAX) begin
            r = Q_MAX;
        end else if (r < Q_MIN) begin
            r = Q_MIN;
        end
        return r[qWidth-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < nCols; c++) begin
            for (int b = 0; b < nBanks; b++) begin
                sum_w[c][b] = acc_q[c][b] + ACC_W'($signed(din[(b*nCols+c)*oWidth +: oWidth]));
            end
        end
    end

    always_comb begin
        acc_active = 1'b0;
        for (int c = 0; c < nCols; c++) begin
            cnt_d[c]         = cnt_q[c];
            stage_valid_d[c] = 1'b0;
            for (int b = 0; b < nBanks; b++) begin
                acc_d[c][b]   = acc_q[c][b];
                stage_d[c][b] = stage_q[c][b];
            end
            if (din_en[c]) begin
                if (cnt_q[c] == npass_q - CW'(1)) begin
                    cnt_d[c]         = '0;
                    stage_valid_d[c] = 1'b1;
                    for (int b = 0; b < nBanks; b++) begin
                        stage_d[c][b] = sum_w[c][b];
                        acc_d[c][b]   = '0;
                    end
                end else begin
                    cnt_d[c] = cnt_q[c] + CW'(1);
                    for (int b = 0; b < nBanks; b++) begin
                        acc_d[c][b] = sum_w[c][b];
                    end
                end
            end
            if (cnt_q[c] != '0 || stage_valid_q[c]) begin
                acc_active = 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < nCols; c++) begin
            q_data[c] = '0;
            for (int b = 0; b < nBanks; b++) begin
                q_data[c][b*qWidth +: qWidth] = quantize(stage_q[c][b], shift_q, relu_q);
            end
        end
    end

    for (genvar c = 0; c < nCols; c++) begin : g_fifo
        collector_fifo #(
            .WIDTH (QD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (stage_valid_q[c]),
            .push_data (q_data[c]),
            .pop       (fifo_pop[c]),
            .pop_data  (fifo_head[c]),
            .full      (fifo_full[c]),
            .empty     (fifo_empty[c]),
            .dropped   (fifo_drop[c])
        );
    end

    // A presented entry is locked until accepted, so later arrivals cannot reshuffle the grant.
    always_comb begin
        found    = 1'b0;
        pick_col = ptr_q;
        cand     = '0;
        for (int i = 0; i < nCols; i++) begin
            cand = CIDX_W'((int'(ptr_q) + i) % nCols);
            if (!found && !fifo_empty[cand]) begin
                found    = 1'b1;
                pick_col = cand;
            end
        end
        cur_col    = lock_q ? lock_col_q : pick_col;
        out_valid  = lock_q | found;
        handshake  = out_valid & out_ready;
        out_data   = out_valid ? fifo_head[cur_col] : '0;
        out_col    = out_valid ? cur_col : '0;
        lock_d     = out_valid & ~out_ready;
        lock_col_d = cur_col;
        ptr_d      = ptr_q;
        if (handshake) begin
            ptr_d = (cur_col == CIDX_W'(nCols - 1)) ? '0 : cur_col + 1'b1;
        end
        for (int c = 0; c < nCols; c++) begin
            fifo_pop[c] = handshake && (cur_col == CIDX_W'(c));
        end
        ovf_d = ovf_q | fifo_drop;
    end

    assign busy = acc_active | ~&fifo_empty;
    assign ovf  = ovf_q;

    always_comb begin
        state_d = state_q;
        npass_d = npass_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        if (cfg_load && state_q == ST_IDLE && !busy) begin
            npass_d = cfg_npass;
            shift_d = cfg_shift;
            relu_d  = cfg_relu;
        end
        case (state_q)
            ST_IDLE:  if (|din_en) state_d = ST_RUN;
            ST_RUN:   if (!acc_active && !(|din_en)) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (|din_en) begin
                    state_d = ST_RUN;
                end else if (&fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            npass_q       <= CW'(1);
            shift_q       <= '0;
            relu_q        <= 1'b0;
            stage_valid_q <= '0;
            ovf_q         <= '0;
            ptr_q         <= '0;
            lock_q        <= 1'b0;
            lock_col_q    <= '0;
            for (int c = 0; c < nCols; c++) begin
                cnt_q[c] <= '0;
                for (int b = 0; b < nBanks; b++) begin
                    acc_q[c][b]   <= '0;
                    stage_q[c][b] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            npass_q       <= npass_d;
            shift_q       <= shift_d;
            relu_q        <= relu_d;
            stage_valid_q <= stage_valid_d;
            ovf_q         <= ovf_d;
            ptr_q         <= ptr_d;
            lock_q        <= lock_d;
            lock_col_q    <= lock_col_d;
            for (int c = 0; c < nCols; c++) begin
                cnt_q[c] <= cnt_d[c];
                for (int b = 0; b < nBanks; b++) begin
                    acc_q[c][b]   <= acc_d[c][b];
                    stage_q[c][b] <= stage_d[c][b];
                end
            end
        end
    end

endmodule

// File: tb/tb_output_collector.sv
// tb/tb_output_collector.sv - directed self-checking bench for output_collector
module tb_output_collector;

    localparam int NB = 2;
    localparam int NC = 4;
    localparam int OW = 33;
    localparam int QW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_load;
    logic [3:0]           cfg_npass;
    logic [4:0]           cfg_shift;
    logic                 cfg_relu;
    logic [NB*NC*OW-1:0]  din;
    logic [NC-1:0]        din_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [NB*QW-1:0]     out_data;
    logic [1:0]           out_col;
    logic                 busy;
    logic [NC-1:0]        ovf;

    int checks = 0;
    int errors = 0;

    output_collector dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_npass (cfg_npass),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .din       (din),
        .din_en    (din_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] word(input int b);
        logic signed [QW-1:0] w;
        w = out_data[b*QW +: QW];
        return w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_din(input int c, input int b, input int val);
        din[(b*NC+c)*OW +: OW] = OW'(val);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        din_en = '0;
        din = '0;
        cfg_load = 1'b0;
        cyc(2);
        rst = 1'b1;
    endtask

    task automatic cfg(input int np, input int sh, input logic rl);
        cfg_npass = 4'(np);
        cfg_shift = 5'(sh);
        cfg_relu  = rl;
        cfg_load  = 1'b1;
        cyc(1);
        cfg_load  = 1'b0;
    endtask

    task automatic send(input int c, input int b0, input int b1);
        set_din(c, 0, b0);
        set_din(c, 1, b1);
        din_en = '0;
        din_en[c] = 1'b1;
        cyc(1);
        din_en = '0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_load = 1'b0;
        cfg_npass = '0;
        cfg_shift = '0;
        cfg_relu = 1'b0;
        din = '0;
        din_en = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_col", out_col, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);

        // npass=1 pass-through on column 2
        out_ready = 1'b1;
        send(2, 100, -5);
        check("pt_valid_early", out_valid, 0);
        check("pt_busy", busy, 1);
        cyc(1);
        check("pt_valid", out_valid, 1);
        check("pt_col", out_col, 2);
        check("pt_w0", word(0), 100);
        check("pt_w1", word(1), -5);
        cyc(1);
        check("pt_drained", out_valid, 0);

        // three-pass accumulation with rounding shift
        do_reset();
        cfg(3, 2, 1'b0);
        send(0, 10, 7);
        cyc(2);
        check("acc_none1", out_valid, 0);
        send(0, 20, 0);
        cyc(2);
        check("acc_none2", out_valid, 0);
        send(0, 30, 0);
        cyc(1);
        check("acc_valid", out_valid, 1);
        check("acc_col", out_col, 0);
        check("acc_w0", word(0), 15);
        check("acc_w1", word(1), 2);
        cyc(1);
        check("acc_single", out_valid, 0);

        // ReLU and saturation
        do_reset();
        cfg(1, 0, 1'b1);
        send(1, -1000, 1 << 20);
        cyc(1);
        check("relu_w0", word(0), 0);
        check("relu_sat_w1", word(1), 32767);
        cyc(4);
        check("relu_idle", busy, 0);
        cfg(1, 0, 1'b0);
        send(1, 1 << 20, -(1 << 20));
        cyc(1);
        check("sat_pos", word(0), 32767);
        check("sat_neg", word(1), -32768);

        // all columns at once drain in column order
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < NC; c++) begin
            set_din(c, 0, 100 + c);
            set_din(c, 1, -c);
        end
        din_en = 4'hF;
        cyc(1);
        din_en = '0;
        cyc(1);
        for (int c = 0; c < NC; c++) begin
            check("par_valid", out_valid, 1);
            check("par_col", out_col, c);
            check("par_w0", word(0), 100 + c);
            check("par_w1", word(1), -c);
            cyc(1);
        end
        check("par_done", out_valid, 0);

        // overflow: nine completions into a depth-8 FIFO with the sink stalled
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            set_din(1, 0, k);
            set_din(1, 1, -k);
            din_en = 4'b0010;
            cyc(1);
        end
        din_en = '0;
        cyc(2);
        check("ovf_flag", ovf, 4'b0010);
        check("ovf_hold_col", out_col, 1);
        check("ovf_hold_w0", word(0), 1);
        cyc(1);
        check("ovf_stable_w0", word(0), 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("ovf_drain_col", out_col, 1);
            check("ovf_drain_w0", word(0), k);
            check("ovf_drain_w1", word(1), -k);
            cyc(1);
        end
        check("ovf_empty", out_valid, 0);
        check("ovf_sticky", ovf, 4'b0010);

        // reset mid-accumulation, then cfg_load while busy is ignored
        do_reset();
        cfg(3, 0, 1'b0);
        send(3, 1000, 1000);
        send(3, 2000, 2000);
        check("mid_busy", busy, 1);
        do_reset();
        check("mid_rst_busy", busy, 0);
        cfg(3, 0, 1'b0);
        send(3, 1, -1);
        cfg(1, 4, 1'b1);
        cyc(1);
        check("ign_no_entry", out_valid, 0);
        send(3, 2, -2);
        cyc(2);
        check("ign_no_entry2", out_valid, 0);
        send(3, 3, -3);
        cyc(1);
        check("fresh_valid", out_valid, 1);
        check("fresh_col", out_col, 3);
        check("fresh_w0", word(0), 6);
        check("fresh_w1", word(1), -6);
        cyc(1);
        check("fresh_done", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
